cursor_ctrl: RTL
================

# cursor_ctrl

Downstream consumer of the button/switch debouncer in the MineSweeper design: takes the debounced one-cycle button pulses, debounced button levels and settled switch word, and maintains the player's cursor on the COLS×ROWS board. Hold-to-repeat is implemented for direction keys. Centre presses are turned into board commands (reveal / flag / chord / restart) delivered to the game-logic block over a single-entry valid/ready slot.

## Interface
- COLS, 16, board width in cells (≥2)
- ROWS, 16, board height in cells (≥2)
- XW, 4, cursor_x width, ≥ clog2(COLS)
- YW, 4, cursor_y width, ≥ clog2(ROWS)
- HOLD_DELAY, 25_000_000, cycles a single direction must be held before the first auto-repeat step (≥1)
- REPEAT_PERIOD, 5_000_000, cycles between subsequent auto-repeat steps (≥1)
- clk  in  1  system clock; one clock domain; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- game_active  in  1  high = board accepts input; low = moves and commands ignored
- button_pluse  in  5  debounced one-cycle press pulses: [0] up, [1] down, [2] left, [3] right, [4] centre
- button_out  in  5  debounced button levels, same bit mapping
- SW_OK  in  8  settled switches: [0] flag mode, [1] chord mode, [7] restart; others unused
- cursor_x  out  XW  cursor column, 0..COLS-1
- cursor_y  out  YW  cursor row, 0..ROWS-1
- cmd_valid  out  1  command slot occupied
- cmd_op  out  2  00 reveal, 01 flag, 10 chord, 11 restart
- cmd_x  out  XW  column captured with the command
- cmd_y  out  YW  row captured with the command
- cmd_ready  in  1  consumer accepts the command on a clk edge where cmd_valid=1
- cmd_drop  out  1  one-cycle pulse: centre press lost because the slot was full

## Operation
- Step sources: each cycle, step_dir[3:0] = button_pluse[3:0] OR rpt_step[3:0]. Multiple sources for the same direction in one cycle yield one step.
- Vertical axis: up and down both set → no move. Up: y = (y==0) ? ROWS-1 : y-1. Down: y = (y==ROWS-1) ? 0 : y+1.
- Horizontal axis: left and right both set → no move. Left and right wrap the same way using COLS.
- Vertical and horizontal steps in the same cycle both apply (diagonal).
- Auto-repeat FSM, with a 32-bit counter cnt:
  - IDLE → DELAY (cnt=0) when button_out[3:0] is one-hot. The held direction is latched as dir.
  - DELAY: when button_out[3:0] ≠ dir, → IDLE. When cnt==HOLD_DELAY-1, pulse rpt_step=dir, → REPEAT, cnt=0. Otherwise cnt+1.
  - REPEAT: when button_out[3:0] ≠ dir, → IDLE. When cnt==REPEAT_PERIOD-1, pulse rpt_step=dir, cnt=0. Otherwise cnt+1.
  - rpt_step is combinational from state/cnt and is high for exactly one cycle per step.
- Command generation on button_pluse[4] while game_active:
  - op priority: SW_OK[7] → 11; else SW_OK[1] → 10; else SW_OK[0] → 01; else 00.
  - cmd_x/cmd_y = cursor value before any move applied in the same cycle.
  - The press is accepted if (!cmd_valid || cmd_ready). On acceptance the slot loads and cmd_valid=1. Otherwise the slot is unchanged and cmd_drop pulses.
- Slot: cmd_valid/op/x/y hold stable while cmd_valid && !cmd_ready. An edge with cmd_valid && cmd_ready and no new accepted press clears cmd_valid.
- game_active=0: cursor holds, FSM is forced to IDLE with cnt=0, centre presses are ignored without cmd_drop, and a pending command stays until taken.
- A restart command does not move the cursor. The consumer resets the board.

## Timing
- Reset values: cursor_x=0, cursor_y=0, cmd_valid=0, cmd_op=00, cmd_x=0, cmd_y=0, cmd_drop=0, FSM=IDLE, cnt=0.
- Pulse → cursor update visible the next cycle (1-cycle latency).
- Centre pulse → cmd_valid high the next cycle. cmd_drop is registered and high on the cycle after the rejected press.
- First repeat step: a direction held continuously from the pulse cycle gives its first repeat step HOLD_DELAY+1 cycles after the press pulse. Further steps follow every REPEAT_PERIOD cycles.
- Back-to-back: a press in the same cycle as consumer acceptance replaces the command, and cmd_valid stays high.
- rst asserted mid-operation clears everything immediately. A pending command is lost.

## Test plan
- Wrap: reset, then a single left pulse → cursor_x=15, cursor_y=0. Then an up pulse → cursor_y=15. Then a right pulse → cursor_x=0.
- Conflict/diagonal: up+down pulses in the same cycle → y unchanged. Right+down in one cycle from (3,3) → (4,4).
- Auto-repeat with HOLD_DELAY=10, REPEAT_PERIOD=4: hold right from (0,0) for 30 cycles, then release → x=1 after the pulse, x=2 at pulse+11, then +1 every 4 cycles. Final x=6 and the FSM returns to IDLE.
- Command ops: cursor (5,7), SW_OK=0x03, centre pulse → cmd_valid=1, op=10, x=5, y=7. Same press with SW_OK=0x81 → op=11.
- Backpressure: cmd_ready=0, two centre presses → first held, second gives cmd_drop=1 for one cycle. Raise cmd_ready for 1 cycle → cmd_valid=0.
- Inactive/reset: game_active=0 → pulses are ignored, with no cursor move and no cmd_drop. Assert rst while cmd_valid=1 → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/cursor_ctrl.sv
// Board cursor with hold-to-repeat on direction keys; centre presses become
// reveal/flag/chord/restart commands in a single-entry valid/ready slot.
module cursor_ctrl #(
  parameter int COLS          = 16,
  parameter int ROWS          = 16,
  parameter int XW            = 4,
  parameter int YW            = 4,
  parameter int HOLD_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          game_active,
  input  logic [4:0]    button_pluse,
  input  logic [4:0]    button_out,
  input  logic [7:0]    SW_OK,
  output logic [XW-1:0] cursor_x,
  output logic [YW-1:0] cursor_y,
  output logic          cmd_valid,
  output logic [1:0]    cmd_op,
  output logic [XW-1:0] cmd_x,
  output logic [YW-1:0] cmd_y,
  input  logic          cmd_ready,
  output logic          cmd_drop
);

  localparam logic [XW-1:0] L_XMAX      = XW'(COLS - 1);
  localparam logic [YW-1:0] L_YMAX      = YW'(ROWS - 1);
  localparam logic [31:0]   L_HOLD_LAST = 32'(HOLD_DELAY - 1);
  localparam logic [31:0]   L_RPT_LAST  = 32'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  state_t        r_state;
  logic [31:0]   r_cnt;
  logic [3:0]    r_dir;

  logic [XW-1:0] r_cursor_x;
  logic [YW-1:0] r_cursor_y;
  logic          r_cmd_valid;
  logic [1:0]    r_cmd_op;
  logic [XW-1:0] r_cmd_x;
  logic [YW-1:0] r_cmd_y;
  logic          r_cmd_drop;

  logic          w_held;
  logic [3:0]    w_rpt_step;
  logic [3:0]    w_step;
  logic [XW-1:0] w_next_x;
  logic [YW-1:0] w_next_y;
  logic          w_press;
  logic          w_accept;
  logic [1:0]    w_op;
  logic          w_unused;

  assign w_unused = ^{SW_OK[6:2], button_out[4]};

  assign w_held = (button_out[3:0] == r_dir);

  // Step pulse is suppressed on the release cycle so a let-go key never steps.
  always_comb begin
    w_rpt_step = 4'b0000;
    if (game_active && w_held) begin
      case (r_state)
        ST_DELAY:  if (r_cnt == L_HOLD_LAST) w_rpt_step = r_dir;
        ST_REPEAT: if (r_cnt == L_RPT_LAST)  w_rpt_step = r_dir;
        default:   w_rpt_step = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 32'd0;
      r_dir   <= 4'b0000;
    end else if (!game_active) begin
      r_state <= ST_IDLE;
      r_cnt   <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= 32'd0;
          if ($onehot(button_out[3:0])) begin
            r_state <= ST_DELAY;
            r_dir   <= button_out[3:0];
          end
        end
        ST_DELAY: begin
          if (!w_held) begin
            r_state <= ST_IDLE;
            r_cnt   <= 32'd0;
          end else if (r_cnt == L_HOLD_LAST) begin
            r_state <= ST_REPEAT;
            r_cnt   <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        ST_REPEAT: begin
          if (!w_held) begin
            r_state <= ST_IDLE;
            r_cnt   <= 32'd0;
          end else if (r_cnt == L_RPT_LAST) begin
            r_cnt <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 32'd0;
        end
      endcase
    end
  end

  assign w_step = button_pluse[3:0] | w_rpt_step;

  // Opposing directions on one axis cancel; the two axes move independently.
  always_comb begin
    w_next_y = r_cursor_y;
    if (w_step[0] && !w_step[1])
      w_next_y = (r_cursor_y == '0) ? L_YMAX : r_cursor_y - YW'(1);
    else if (w_step[1] && !w_step[0])
      w_next_y = (r_cursor_y == L_YMAX) ? '0 : r_cursor_y + YW'(1);

    w_next_x = r_cursor_x;
    if (w_step[2] && !w_step[3])
      w_next_x = (r_cursor_x == '0) ? L_XMAX : r_cursor_x - XW'(1);
    else if (w_step[3] && !w_step[2])
      w_next_x = (r_cursor_x == L_XMAX) ? '0 : r_cursor_x + XW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cursor_x <= '0;
      r_cursor_y <= '0;
    end else if (game_active) begin
      r_cursor_x <= w_next_x;
      r_cursor_y <= w_next_y;
    end
  end

  always_comb begin
    w_op = 2'b00;
    if (SW_OK[7])      w_op = 2'b11;
    else if (SW_OK[1]) w_op = 2'b10;
    else if (SW_OK[0]) w_op = 2'b01;
  end

  assign w_press  = game_active && button_pluse[4];
  assign w_accept = w_press && (!r_cmd_valid || cmd_ready);

  // The slot captures the pre-move cursor; a taken command is replaced in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_valid <= 1'b0;
      r_cmd_op    <= 2'b00;
      r_cmd_x     <= '0;
      r_cmd_y     <= '0;
      r_cmd_drop  <= 1'b0;
    end else begin
      r_cmd_drop <= w_press && !w_accept;
      if (w_accept) begin
        r_cmd_valid <= 1'b1;
        r_cmd_op    <= w_op;
        r_cmd_x     <= r_cursor_x;
        r_cmd_y     <= r_cursor_y;
      end else if (r_cmd_valid && cmd_ready) begin
        r_cmd_valid <= 1'b0;
      end
    end
  end

  assign cursor_x  = r_cursor_x;
  assign cursor_y  = r_cursor_y;
  assign cmd_valid = r_cmd_valid;
  assign cmd_op    = r_cmd_op;
  assign cmd_x     = r_cmd_x;
  assign cmd_y     = r_cmd_y;
  assign cmd_drop  = r_cmd_drop;

endmodule
